// File: rtl/hockey_input_conditioner.sv
// hockey_input_conditioner: two independent player channels that synchronize,
// debounce and capture button/direction/row inputs for the hockey core.
// Optional range check on captured values: define HOCKEY_RANGE_CHECK_EN.

module hockey_input_channel #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_raw,
  input  logic [1:0] i_dir_raw,
  input  logic [2:0] i_y_raw,
  output logic       o_btn,
  output logic [1:0] o_dir,
`ifdef HOCKEY_RANGE_CHECK_EN
  output logic [2:0] o_y,
  output logic       o_err
`else
  output logic [2:0] o_y
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_btn_s1;
  logic             r_btn_s2;
  logic [1:0]       r_dir_s1;
  logic [1:0]       r_dir_s2;
  logic [2:0]       r_y_s1;
  logic [2:0]       r_y_s2;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             w_fire;

  logic             r_btn;
  logic [1:0]       r_dir;
  logic [2:0]       r_y;

`ifdef HOCKEY_RANGE_CHECK_EN
  logic             w_bad;
  logic             w_reject;
  logic             r_err;
`endif

  // two-flop synchronizers on every raw input
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_dir_s1 <= 2'd0;
      r_dir_s2 <= 2'd0;
      r_y_s1   <= 3'd0;
      r_y_s2   <= 3'd0;
    end else begin
      r_btn_s1 <= i_btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_dir_s1 <= i_dir_raw;
      r_dir_s2 <= r_dir_s1;
      r_y_s1   <= i_y_raw;
      r_y_s2   <= r_y_s1;
    end
  end

  // debounce state and counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // debounce next-state: a level is accepted after DEBOUNCE_CYCLES
  // consecutive matching samples; any mismatch restarts the wait
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_btn_s2) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!r_btn_s2) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_accept    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!r_btn_s2) begin
          w_state_nxt = REL_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      REL_WAIT: begin
        if (r_btn_s2) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef HOCKEY_RANGE_CHECK_EN
  // a press carrying an illegal direction or row is turned into an error
  always_comb begin
    w_bad    = (r_dir_s2 == 2'd3) || (r_y_s2 > 3'd4);
    w_fire   = w_accept && !w_bad;
    w_reject = w_accept && w_bad;
  end
`else
  // every accepted press is forwarded
  always_comb begin
    w_fire = w_accept;
  end
`endif

  // registered event pulse and argument capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btn <= 1'b0;
      r_dir <= 2'd0;
      r_y   <= 3'd0;
    end else begin
      r_btn <= w_fire;
      if (w_fire) begin
        r_dir <= r_dir_s2;
        r_y   <= r_y_s2;
      end
    end
  end

`ifdef HOCKEY_RANGE_CHECK_EN
  // registered rejection pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_reject;
    end
  end

  assign o_err = r_err;
`endif

  assign o_btn = r_btn;
  assign o_dir = r_dir;
  assign o_y   = r_y;

endmodule

module hockey_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BTN_A_RAW,
  input  logic       BTN_B_RAW,
  input  logic [1:0] DIR_A_RAW,
  input  logic [1:0] DIR_B_RAW,
  input  logic [2:0] Y_A_RAW,
  input  logic [2:0] Y_B_RAW,
  output logic       BTN_A,
  output logic       BTN_B,
  output logic [1:0] DIR_A,
  output logic [1:0] DIR_B,
  output logic [2:0] Y_in_A,
`ifdef HOCKEY_RANGE_CHECK_EN
  output logic [2:0] Y_in_B,
  output logic       ERR_A,
  output logic       ERR_B
`else
  output logic [2:0] Y_in_B
`endif
);

  hockey_input_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_a (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_btn_raw(BTN_A_RAW),
    .i_dir_raw(DIR_A_RAW),
    .i_y_raw  (Y_A_RAW),
    .o_btn    (BTN_A),
    .o_dir    (DIR_A),
`ifdef HOCKEY_RANGE_CHECK_EN
    .o_y      (Y_in_A),
    .o_err    (ERR_A)
`else
    .o_y      (Y_in_A)
`endif
  );

  hockey_input_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_b (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_btn_raw(BTN_B_RAW),
    .i_dir_raw(DIR_B_RAW),
    .i_y_raw  (Y_B_RAW),
    .o_btn    (BTN_B),
    .o_dir    (DIR_B),
`ifdef HOCKEY_RANGE_CHECK_EN
    .o_y      (Y_in_B),
    .o_err    (ERR_B)
`else
    .o_y      (Y_in_B)
`endif
  );

endmodule

// File: tb/tb_hockey_input_conditioner.sv
// Bench for hockey_input_conditioner: run-length reference model checked
// every cycle plus directed scenarios with hand-computed expectations.

module tb_hockey_input_conditioner;

  localparam int D = 16;
`ifdef HOCKEY_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw [2];
  logic [1:0] dir_raw [2];
  logic [2:0] y_raw   [2];

  logic       BTN_A;
  logic       BTN_B;
  logic [1:0] DIR_A;
  logic [1:0] DIR_B;
  logic [2:0] Y_in_A;
  logic [2:0] Y_in_B;
`ifdef HOCKEY_RANGE_CHECK_EN
  logic       ERR_A;
  logic       ERR_B;
`endif

  always #5 clk = ~clk;

  hockey_input_conditioner #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .BTN_A_RAW(btn_raw[0]),
    .BTN_B_RAW(btn_raw[1]),
    .DIR_A_RAW(dir_raw[0]),
    .DIR_B_RAW(dir_raw[1]),
    .Y_A_RAW  (y_raw[0]),
    .Y_B_RAW  (y_raw[1]),
    .BTN_A    (BTN_A),
    .BTN_B    (BTN_B),
    .DIR_A    (DIR_A),
    .DIR_B    (DIR_B),
    .Y_in_A   (Y_in_A),
`ifdef HOCKEY_RANGE_CHECK_EN
    .Y_in_B   (Y_in_B),
    .ERR_A    (ERR_A),
    .ERR_B    (ERR_B)
`else
    .Y_in_B   (Y_in_B)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h at t=%0t",
                  nm, act, exp, $time);
  endtask

  // reference model: two-sample delay, then a level is accepted once the
  // delayed input has differed from the accepted level for D samples in a row
  int         cyc = 0;
  bit         started = 1'b0;
  logic       m_p1 [2];
  logic       m_p2 [2];
  logic [1:0] m_d1 [2];
  logic [1:0] m_d2 [2];
  logic [2:0] m_y1 [2];
  logic [2:0] m_y2 [2];
  logic       m_lvl [2];
  int         m_run [2];
  logic       m_btn [2];
  logic [1:0] m_dir [2];
  logic [2:0] m_yo  [2];
  logic       m_err [2];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        started  <= 1'b1;
        m_p1[c]  <= 1'b0;
        m_p2[c]  <= 1'b0;
        m_d1[c]  <= 2'd0;
        m_d2[c]  <= 2'd0;
        m_y1[c]  <= 3'd0;
        m_y2[c]  <= 3'd0;
        m_lvl[c] <= 1'b0;
        m_run[c] <= 0;
        m_btn[c] <= 1'b0;
        m_dir[c] <= 2'd0;
        m_yo[c]  <= 3'd0;
        m_err[c] <= 1'b0;
      end else begin
        m_p1[c]  <= btn_raw[c];
        m_p2[c]  <= m_p1[c];
        m_d1[c]  <= dir_raw[c];
        m_d2[c]  <= m_d1[c];
        m_y1[c]  <= y_raw[c];
        m_y2[c]  <= m_y1[c];
        m_btn[c] <= 1'b0;
        m_err[c] <= 1'b0;
        if (m_p2[c] != m_lvl[c]) begin
          if (m_run[c] + 1 == D) begin
            m_lvl[c] <= m_p2[c];
            m_run[c] <= 0;
            if (m_p2[c]) begin
              if (!RC || (m_d2[c] != 2'd3 && m_y2[c] <= 3'd4)) begin
                m_btn[c] <= 1'b1;
                m_dir[c] <= m_d2[c];
                m_yo[c]  <= m_y2[c];
              end else begin
                m_err[c] <= 1'b1;
              end
            end
          end else begin
            m_run[c] <= m_run[c] + 1;
          end
        end else begin
          m_run[c] <= 0;
        end
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("BTN_A", {7'd0, BTN_A}, {7'd0, m_btn[0]});
      chk("BTN_B", {7'd0, BTN_B}, {7'd0, m_btn[1]});
      chk("DIR_A", {6'd0, DIR_A}, {6'd0, m_dir[0]});
      chk("DIR_B", {6'd0, DIR_B}, {6'd0, m_dir[1]});
      chk("Y_in_A", {5'd0, Y_in_A}, {5'd0, m_yo[0]});
      chk("Y_in_B", {5'd0, Y_in_B}, {5'd0, m_yo[1]});
`ifdef HOCKEY_RANGE_CHECK_EN
      chk("ERR_A", {7'd0, ERR_A}, {7'd0, m_err[0]});
      chk("ERR_B", {7'd0, ERR_B}, {7'd0, m_err[1]});
`endif
    end
  end

  // pulse counters for the directed literal checks
  int pa = 0;
  int pb = 0;
  int ea = 0;
  int pcyc_a = -1;
  int pcyc_b = -1;

  always @(negedge clk) begin
    if (BTN_A === 1'b1) begin
      pa     = pa + 1;
      pcyc_a = cyc;
    end
    if (BTN_B === 1'b1) begin
      pb     = pb + 1;
      pcyc_b = cyc;
    end
`ifdef HOCKEY_RANGE_CHECK_EN
    if (ERR_A === 1'b1) ea = ea + 1;
`endif
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int t0;

  initial begin
    for (int c = 0; c < 2; c++) begin
      btn_raw[c] = 1'b0;
      dir_raw[c] = 2'd0;
      y_raw[c]   = 3'd0;
    end
    rst = 1'b1;
    idle(3);
    chk("rst_BTN_A", {7'd0, BTN_A}, 8'd0);
    chk("rst_DIR_A", {6'd0, DIR_A}, 8'd0);
    chk("rst_Y_in_B", {5'd0, Y_in_B}, 8'd0);
    rst = 1'b0;
    idle(5);

    // single long press on A
    dir_raw[0] = 2'd0;
    y_raw[0]   = 3'd3;
    pa = 0;
    pb = 0;
    btn_raw[0] = 1'b1;
    t0 = cyc;
    idle(200);
    btn_raw[0] = 1'b0;
    idle(40);
    chk("t1_pulses_a", 8'(pa), 8'd1);
    chk("t1_latency", 8'(pcyc_a - t0), 8'd18);
    chk("t1_DIR_A", {6'd0, DIR_A}, 8'd0);
    chk("t1_Y_in_A", {5'd0, Y_in_A}, 8'd3);
    chk("t1_pulses_b", 8'(pb), 8'd0);
    chk("t1_Y_in_B", {5'd0, Y_in_B}, 8'd0);

    // glitch train on B, then a clean press
    dir_raw[1] = 2'd1;
    y_raw[1]   = 3'd1;
    btn_raw[1] = 1'b1; idle(5);
    btn_raw[1] = 1'b0; idle(3);
    btn_raw[1] = 1'b1; idle(7);
    btn_raw[1] = 1'b0; idle(20);
    chk("t2_glitch_b", 8'(pb), 8'd0);
    dir_raw[1] = 2'd2;
    y_raw[1]   = 3'd2;
    btn_raw[1] = 1'b1; idle(40);
    btn_raw[1] = 1'b0; idle(40);
    chk("t2_pulses_b", 8'(pb), 8'd1);
    chk("t2_DIR_B", {6'd0, DIR_B}, 8'd2);
    chk("t2_Y_in_B", {5'd0, Y_in_B}, 8'd2);

    // mid-hold dropout, then short-release and exact-length boundaries
    pa = 0;
    dir_raw[0] = 2'd1;
    y_raw[0]   = 3'd4;
    btn_raw[0] = 1'b1; idle(30);
    btn_raw[0] = 1'b0; idle(4);
    btn_raw[0] = 1'b1; idle(100);
    btn_raw[0] = 1'b0; idle(15);
    btn_raw[0] = 1'b1; idle(30);
    chk("t3_one_pulse", 8'(pa), 8'd1);
    btn_raw[0] = 1'b0; idle(20);
    dir_raw[0] = 2'd2;
    y_raw[0]   = 3'd1;
    btn_raw[0] = 1'b1; idle(40);
    btn_raw[0] = 1'b0; idle(40);
    chk("t3_two_pulses", 8'(pa), 8'd2);
    chk("t3_DIR_A", {6'd0, DIR_A}, 8'd2);
    chk("t3_Y_in_A", {5'd0, Y_in_A}, 8'd1);
    btn_raw[0] = 1'b1; idle(15);
    btn_raw[0] = 1'b0; idle(30);
    chk("t3_15_samples", 8'(pa), 8'd2);
    btn_raw[0] = 1'b1; idle(16);
    btn_raw[0] = 1'b0; idle(30);
    chk("t3_16_samples", 8'(pa), 8'd3);

    // simultaneous presses
    pa = 0;
    pb = 0;
    dir_raw[0] = 2'd1; y_raw[0] = 3'd1;
    dir_raw[1] = 2'd1; y_raw[1] = 3'd2;
    btn_raw[0] = 1'b1;
    btn_raw[1] = 1'b1;
    t0 = cyc;
    idle(30);
    dir_raw[0] = 2'd3; y_raw[0] = 3'd7;
    dir_raw[1] = 2'd0; y_raw[1] = 3'd5;
    idle(30);
    chk("t4_same_cycle", 8'(pcyc_a - pcyc_b), 8'd0);
    chk("t4_latency_b", 8'(pcyc_b - t0), 8'd18);
    chk("t4_DIR_A", {6'd0, DIR_A}, 8'd1);
    chk("t4_Y_in_A", {5'd0, Y_in_A}, 8'd1);
    chk("t4_DIR_B", {6'd0, DIR_B}, 8'd1);
    chk("t4_Y_in_B", {5'd0, Y_in_B}, 8'd2);
    btn_raw[0] = 1'b0;
    btn_raw[1] = 1'b0;
    idle(40);
    chk("t4_pulses", 8'(pa + pb), 8'd2);

    // reset during press debounce
    dir_raw[0] = 2'd2; y_raw[0] = 3'd2;
    btn_raw[0] = 1'b1;
    idle(10);
    pa = 0;
    rst = 1'b1;
    idle(1);
    chk("t5_rst_BTN_A", {7'd0, BTN_A}, 8'd0);
    chk("t5_rst_DIR_A", {6'd0, DIR_A}, 8'd0);
    chk("t5_rst_Y_in_A", {5'd0, Y_in_A}, 8'd0);
    chk("t5_rst_DIR_B", {6'd0, DIR_B}, 8'd0);
    rst = 1'b0;
    t0 = cyc;
    idle(40);
    chk("t5_pulses", 8'(pa), 8'd1);
    chk("t5_latency", 8'(pcyc_a - t0), 8'd18);
    btn_raw[0] = 1'b0;
    idle(40);

    // out-of-range row
    pa = 0;
    ea = 0;
    dir_raw[0] = 2'd0; y_raw[0] = 3'd6;
    btn_raw[0] = 1'b1; idle(40);
    btn_raw[0] = 1'b0; idle(40);
`ifdef HOCKEY_RANGE_CHECK_EN
    chk("t6_err_a", 8'(ea), 8'd1);
    chk("t6_no_btn", 8'(pa), 8'd0);
    chk("t6_Y_in_A", {5'd0, Y_in_A}, 8'd2);
`else
    chk("t6_btn", 8'(pa), 8'd1);
    chk("t6_Y_in_A", {5'd0, Y_in_A}, 8'd6);
    chk("t6_DIR_A", {6'd0, DIR_A}, 8'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
